// File: rtl/input_controller_pkg.sv
// Shared CPU constants: opcodes, the input-controller FSM encoding, and the
// switch-to-word conversion used when an IN instruction completes.
package input_controller_pkg;

    localparam logic [5:0] OP_IN  = 6'b011101;
    localparam logic [5:0] OP_OUT = 6'b100000;
    localparam logic [5:0] OP_HLT = 6'b011100;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        DONE         = 2'd2,
        WAIT_RELEASE = 2'd3
    } in_state_t;

    // Sign-magnitude switches to 32-bit two's complement; negative zero maps to 0.
    function automatic logic [31:0] to_signed_word(input logic [17:0] sw);
        logic [31:0] mag;
        mag = {15'b0, sw[16:0]};
        return sw[17] ? -mag : mag;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus counter debouncer for an active-low pushbutton.
// pressed is active-high and only follows the key after it has been stable.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic pressed
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_ff;
    logic [CW-1:0] count;
    logic          level;
    logic          key_now;

    assign key_now = ~sync_ff[1];
    assign pressed = level;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_ff <= 2'b11;
            count   <= '0;
            level   <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], key};
            // Any sample agreeing with the current level restarts the run.
            if (key_now != level) begin
                if (count == LAST_COUNT) begin
                    level <= key_now;
                    count <= '0;
                end else begin
                    count <= count + CW'(1);
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/input_controller.sv
// IN-instruction handler: stalls the CPU until the operator confirms with a
// fresh key press, then latches the signed switch value for one-cycle delivery.
module input_controller
    import input_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  operation,
    input  logic [17:0] switches,
    input  logic        confirmKey,
    output logic        stall,
    output logic [31:0] inData,
    output logic        inValid,
    output logic        waitLED
);

    in_state_t state;
    in_state_t next_state;
    logic      pressed;
    logic      pressed_q;
    logic      press_edge;
    logic      is_in;
    logic      capture;
    logic      stall_raw;
    logic      wait_raw;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock  (clock),
        .reset  (reset),
        .key    (confirmKey),
        .pressed(pressed)
    );

    assign is_in      = (operation == OP_IN);
    assign press_edge = pressed & ~pressed_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            pressed_q <= 1'b0;
            inData    <= '0;
        end else begin
            state     <= next_state;
            pressed_q <= pressed;
            if (capture) begin
                inData <= to_signed_word(switches);
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        stall_raw  = 1'b0;
        wait_raw   = 1'b0;
        case (state)
            IDLE: begin
                stall_raw = is_in;
                if (is_in) begin
                    next_state = pressed ? WAIT_RELEASE : WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                stall_raw = 1'b1;
                wait_raw  = 1'b1;
                if (!is_in) begin
                    next_state = IDLE;
                end else if (press_edge) begin
                    capture    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = pressed ? WAIT_RELEASE : IDLE;
            end
            WAIT_RELEASE: begin
                // A key still held from the previous capture must be released first.
                stall_raw = is_in;
                wait_raw  = is_in;
                if (!pressed) begin
                    next_state = is_in ? WAIT_PRESS : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign stall   = reset & stall_raw;
    assign waitLED = reset & wait_raw;
    assign inValid = reset & (state == DONE);

endmodule
